// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load handshake between a value producer and the
// seg_scan_ctrl display controller.
//   master - producer side (drives load_valid / load_value)
//   slave  - controller side (drives load_ready)
interface seg_scan_ctrl_if #(
    parameter int VALUE_W = 14
) ();
    logic               load_valid;
    logic               load_ready;
    logic [VALUE_W-1:0] load_value;

    modport master (
        output load_valid,
        output load_value,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        output load_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment display controller.
// A binary value arrives over a valid/ready handshake. It is converted to BCD
// one bit per cycle (shift-add-3) and committed atomically to the display
// register. The committed digits are then scanned one at a time onto a shared
// downstream decoder through `digit`, with active-low enables on `an`.
// Values above 10^NUM_DIGITS-1 are shown as all nines with `overflow` set.
//
// Optional feature: define SEG_SCAN_LZB_EN to blank leading zeros.
// Digit 0 is never blanked.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_ctrl_if.slave        load_if,
    output logic [3:0]            digit,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CMP_W = VALUE_W + 1;
    localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Largest displayable value, clamped to what CMP_W bits can hold so that a
    // narrow VALUE_W simply never saturates.
    function automatic logic [CMP_W-1:0] max_display();
        longint lim;
        longint cap;
        lim = 1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lim = lim * 10;
        end
        lim = lim - 1;
        cap = (longint'(1) << CMP_W) - 1;
        return CMP_W'((lim > cap) ? cap : lim);
    endfunction

    localparam logic [CMP_W-1:0] MAX_VAL = max_display();

    // Add 3 to every nibble that is 5 or more. The result of such a nibble is
    // at most 12, so a 4-bit add never carries out.
    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VALUE_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               sat_q, sat_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               accept;
    logic               last_bit;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_step;
    logic [NUM_DIGITS-1:0] blank;

    // FSM state register; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: IDLE waits for a handshake, CONVERT runs VALUE_W bits
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = CONVERT;
            CONVERT: if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready only when idle, busy only while converting
    always_comb begin
        load_if.load_ready = (state_q == IDLE);
        busy               = (state_q == CONVERT);
    end

    // Handshake detection, last-bit decode and one shift-add-3 step
    always_comb begin
        accept   = load_if.load_valid && (state_q == IDLE);
        last_bit = (state_q == CONVERT) && (cnt_q == CNT_W'(VALUE_W - 1));
        bcd_adj  = add3_nibbles(bcd_q);
        bcd_step = {bcd_adj[BCD_W-2:0], shift_q[VALUE_W-1]};
    end

    // Conversion datapath next values: capture on accept, shift while converting
    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        if (accept) begin
            shift_d = load_if.load_value;
            bcd_d   = '0;
            sat_d   = ({1'b0, load_if.load_value} > MAX_VAL);
            cnt_d   = '0;
        end else if (state_q == CONVERT) begin
            shift_d = shift_q << 1;
            bcd_d   = bcd_step;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Commit: display and overflow change together on the last conversion bit
    always_comb begin
        disp_d = disp_q;
        ovf_d  = ovf_q;
        if (last_bit) begin
            disp_d = sat_q ? {NUM_DIGITS{4'h9}} : bcd_step;
            ovf_d  = sat_q;
        end
    end

    // Conversion scratch registers need no reset; they are loaded on accept
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        bcd_q   <= bcd_d;
        sat_q   <= sat_d;
    end

    // Bit counter, committed display and overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
        end
    end

    // Scan timing: prescaler terminal count advances the digit index
    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Scan registers run freely, independent of the conversion FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic upper_zero;

    // Leading-zero blanking: digit i>0 is dark when it and all above it are zero
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (disp_q[4*i +: 4] == 4'd0);
            blank[i]   = upper_zero;
        end
    end
`else
    // No blanking: every digit lights in its slot
    always_comb begin
        blank = '0;
    end
`endif

    // Digit mux and active-low enable for the currently scanned index
    always_comb begin
        digit = 4'd0;
        an    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit = disp_q[4*i +: 4];
                an[i] = blank[i];
            end
        end
    end

    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed plus randomized bench for seg_scan_ctrl with
// NUM_DIGITS=4, VALUE_W=14, SCAN_DIV=4. The reference model keeps the
// committed value as a plain integer and derives the expected digit/enable
// from decimal arithmetic and the number of clock edges since reset.
// Honours SEG_SCAN_LZB_EN the same way the design does.
module tb_seg_scan_ctrl;

    localparam int N    = 4;
    localparam int VW   = 14;
    localparam int SD   = 4;
    localparam int MAXV = 9999;

    logic         clk;
    logic         rst;
    logic [3:0]   digit;
    logic [N-1:0] an;
    logic         busy;
    logic         overflow;

    seg_scan_ctrl_if #(.VALUE_W(VW)) lif ();

    seg_scan_ctrl #(
        .NUM_DIGITS(N),
        .VALUE_W   (VW),
        .SCAN_DIV  (SD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load_if (lif),
        .digit   (digit),
        .an      (an),
        .busy    (busy),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; drives the scan reference
    int k;
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int disp_m   = 0;
    int ov_m     = 0;
    int last_acc = 0;
    int prev_acc = 0;

    function automatic int pow10(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_scan();
        int idx;
        int upper;
        logic [31:0] exp_an;
        idx    = (k / SD) % N;
        upper  = disp_m / pow10(idx);
        exp_an = ((~(32'd1 << idx)) & ((32'd1 << N) - 1));
`ifdef SEG_SCAN_LZB_EN
        if (idx > 0 && upper == 0) exp_an = (32'd1 << N) - 1;
`endif
        check("digit", digit, upper % 10);
        check("an", an, exp_an);
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check("busy_idle", busy, 0);
            check_scan();
        end
    endtask

    // Present v, wait (bounded) for acceptance, follow the conversion cycle by
    // cycle, then update the model at the commit edge. Entered at a negedge.
    task automatic do_load(input int v, input bit keep, input int nv);
        bit got;
        got = 1'b0;
        lif.load_valid = 1'b1;
        lif.load_value = VW'(v);
        for (int w = 0; w < 40; w++) begin
            if (lif.load_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            check_scan();
        end
        check("accept_wait", got, 1);
        if (!got) begin
            lif.load_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        prev_acc = last_acc;
        last_acc = k;
        if (keep) begin
            lif.load_valid = 1'b1;
            lif.load_value = VW'(nv);
        end else begin
            lif.load_valid = 1'b0;
        end
        for (int c = 0; c < VW; c++) begin
            @(negedge clk);
            check("busy", busy, 1);
            check("ready_busy", lif.load_ready, 0);
            check_scan();
            @(posedge clk);
        end
        disp_m = (v > MAXV) ? MAXV : v;
        ov_m   = (v > MAXV) ? 1 : 0;
        @(negedge clk);
        check("busy_done", busy, 0);
        check("ready_done", lif.load_ready, 1);
        check("overflow", overflow, ov_m);
        check_scan();
    endtask

    initial begin
        int v;
        rst            = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_value = '0;
        #2 rst = 1'b1;
        #2;
        check("rst_ready", lif.load_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_an", an, 4'b1110);
        check("rst_digit", digit, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic conversion and a full scan refresh
        do_load(1234, 1'b0, 0);
        idle_cycles(2 * N * SD);

        // Saturation, then recovery
        do_load(12000, 1'b0, 0);
        idle_cycles(N * SD);
        do_load(5, 1'b0, 0);
        idle_cycles(N * SD);

        // 42 held while 1234 converts: accepted on the first ready cycle
        do_load(1234, 1'b1, 42);
        do_load(42, 1'b0, 0);
        check("gap_hold", last_acc - prev_acc, VW + 1);
        idle_cycles(N * SD);

        // Leading/inner zeros
        do_load(7, 1'b0, 0);
        idle_cycles(2 * N * SD);
        do_load(1005, 1'b0, 0);
        idle_cycles(N * SD);

        // Back-to-back 9999 then 0
        do_load(9999, 1'b1, 0);
        do_load(0, 1'b0, 0);
        check("gap_b2b", last_acc - prev_acc, VW + 1);
        idle_cycles(N * SD);

        // Randomized values across the whole input range
        for (int r = 0; r < 10; r++) begin
            v = int'($urandom_range(0, (1 << VW) - 1));
            do_load(v, 1'b0, 0);
            idle_cycles(int'($urandom_range(0, 6)));
        end

        // Asynchronous reset in the middle of a conversion
        do_load(1234, 1'b0, 0);
        lif.load_valid = 1'b1;
        lif.load_value = VW'(3210);
        @(posedge clk);
        #1;
        lif.load_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", lif.load_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_an", an, 4'b1110);
        check("mid_rst_digit", digit, 0);
        @(negedge clk);
        rst    = 1'b0;
        disp_m = 0;
        ov_m   = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post_rst_busy", busy, 0);
            check("post_rst_ovf", overflow, 0);
            check_scan();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed display controller for the PWM generator's seven-segment readout. Accepts a binary value over a valid/ready handshake and converts it to BCD sequentially (shift-add-3, one bit per cycle). It then scans the digits so that one shared `seven_segment` decoder instance drives all of them. The decoder sits downstream: this block drives its 4-bit `digit` input and the active-low digit enables.

## Interface
- `NUM_DIGITS`, 4: number of display digits, legal range 1..4.
- `VALUE_W`, 14: width of the loaded binary value.
- `SCAN_DIV`, 50000: clock cycles each digit stays enabled; must be ≥ 2.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  producer presents `load_value`.
- `load_ready`  out  1  controller can accept a value.
- `load_value`  in  VALUE_W  unsigned binary value to display.
- `digit`  out  4  BCD code of the currently scanned digit, fed to the shared decoder.
- `an`  out  NUM_DIGITS  digit enables, active-low, at most one low at a time.
- `busy`  out  1  conversion in progress.
- `overflow`  out  1  last committed value exceeded the display range.

## Operation
- FSM states: IDLE, CONVERT.
- IDLE
  - `load_ready`=1.
  - On `load_valid && load_ready`, capture `load_value` into the shift register, clear the BCD scratch register and go to CONVERT.
  - If `load_value` > 10^NUM_DIGITS−1, latch a saturate flag. The value is then committed as all 9s.
- CONVERT
  - `load_ready`=0, `busy`=1.
  - Each cycle: add 3 to every scratch BCD nibble ≥ 5, then shift left one bit, MSB first from the shift register.
  - A bit counter runs 0..VALUE_W−1.
  - On the last bit, commit in one edge:
    - write the display BCD register (all 9s if saturated),
    - set `overflow` to the saturate flag,
    - return to IDLE.
- Display register changes only at commit, so there is no partial or torn value on the display.
- `load_valid` while busy is ignored; the producer holds the value until `load_ready`.
- Scan, independent of the FSM:
  - Prescaler counts 0..SCAN_DIV−1.
  - At terminal count, digit index advances by 1, wrapping from NUM_DIGITS−1 to 0.
  - `digit` = display nibble[index], combinational from registers.
  - `an` = all ones except bit[index]=0.
- Arithmetic:
  - Scratch BCD width is 4·NUM_DIGITS.
  - Nibble add-3 is 4-bit with no carry out; it cannot overflow when the add condition holds.
  - Comparison against 10^NUM_DIGITS−1 uses VALUE_W+1 bits.
- Reset, asynchronous, including mid-conversion (conversion is aborted):
  - FSM=IDLE
  - display BCD=0
  - index=0
  - prescaler=0
  - `load_ready`=1
  - `busy`=0
  - `overflow`=0
  - `digit`=0
  - `an`=~1, i.e. digit 0 enabled showing "0"

## Timing
- Handshake accepted at edge T. `busy`=1 and `load_ready`=0 for cycles T+1..T+VALUE_W.
- Commit occurs at edge T+VALUE_W. `load_ready` returns to 1 after that edge, so the next accept can happen at edge T+VALUE_W+1.
- Back-to-back loads: one value per VALUE_W+1 cycles.
- Commit coincident with a scan advance: the new index shows committed data in the same cycle.
- Digit dwell is exactly SCAN_DIV cycles. A full refresh takes NUM_DIGITS·SCAN_DIV cycles.
- `digit`/`an` change only after prescaler terminal-count edges, commit edges or reset.

## Configuration
- `SEG_SCAN_LZB_EN`: leading-zero blanking.
- Defined:
  - A digit at index i>0 is blanked when it and all higher display nibbles are zero. Blanked means its `an` bit stays 1 during its slot; `digit` still outputs 0.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the committed display register.
- Undefined: every digit is enabled in its slot, so leading zeros are shown.

## Test plan
- Reset check:
  - Stimulus: assert `rst` asynchronously mid-conversion.
  - Response, immediately: `load_ready`=1, `busy`=0, `overflow`=0, `an`=4'b1110, `digit`=0.
  - After release: display is 0, no commit occurs.
- Load 1234 (NUM_DIGITS=4, VALUE_W=14, SCAN_DIV=4) → `busy` high 14 cycles. Scan then shows `digit`=4,3,2,1 with `an`=1110,1101,1011,0111, each for 4 cycles, and `overflow`=0.
- Load 12000 → committed 9999 with `overflow`=1. A subsequent load of 5 → display 0005 and `overflow`=0.
- Assert `load_valid` with 42 while busy converting 1234 → 42 not accepted until `load_ready`. The 1234 commit is unaffected, then 42 is converted.
- With `SEG_SCAN_LZB_EN` defined, load 7 → only digit 0 ever has `an` low (`an` = 1111 during slots 1..3). Load 1005 → all four digits enabled, inner zeros shown.
- Load 9999 and 0 back-to-back → accept edges exactly 15 cycles apart. The display never shows a mixed value.
